mc_fifo: RTL and testbench
==========================

# mc_fifo

Multi-channel synchronous FIFO: CHANNELS independent logical queues share one write port and one read port. Each channel has its own pointers, fill count and status flags. Storage is one RAM statically partitioned into CHANNELS regions of 2**AWIDTH words. It is the next-generation queue for the datapath: it replaces per-stream single-channel fifo instances where several streams arrive time-multiplexed on one bus.

## Interface
- CHANNELS, 4: number of logical queues, ≥1.
- DWIDTH, 32: data word width.
- AWIDTH, 4: per-channel address width; per-channel depth is 2**AWIDTH.
- ALMOST_FULL_VALUE, 12: almost_full threshold, compared against the channel count.
- ALMOST_EMPTY_VALUE, 4: almost_empty threshold, compared against the channel count.
- Derived localparam CWIDTH = max(1, $clog2(CHANNELS)).

Ports:
- clk_i  in  1  sole clock; all logic on rising edge.
- srst_i  in  1  synchronous, active-high reset.
- data_i  in  DWIDTH  write data.
- wrreq_i  in  1  write request.
- wrch_i  in  CWIDTH  write channel select.
- rdreq_i  in  1  read request.
- rdch_i  in  CWIDTH  read channel select.
- q_o  out  DWIDTH  read data (normal mode, not show-ahead).
- rd_valid_o  out  1  q_o carries a word accepted on the previous cycle.
- rd_ch_o  out  CWIDTH  channel of the word on q_o.
- usedw_o  out  CHANNELS*(AWIDTH+1)  packed per-channel counts; channel c occupies bits [c*(AWIDTH+1) +: AWIDTH+1].
- full_o, empty_o, almost_full_o, almost_empty_o  out  CHANNELS  per-channel flags, bit c = channel c.

## Operation
- Write accept: wrreq_i && wrch_i < CHANNELS && !full[wrch_i]. Word goes to RAM[wrch_i*2**AWIDTH + wptr[wrch_i]]; wptr increments mod 2**AWIDTH.
- Read accept: rdreq_i && rdch_i < CHANNELS && !empty[rdch_i]. The head word is read and rptr increments mod 2**AWIDTH.
- Rejected requests change nothing: full write, empty read, or out-of-range channel.
- No bypass: a read of an empty channel is rejected even if the same channel is written in the same cycle.
- Full write plus same-channel read in the same cycle: the read is accepted and the write is rejected.
- Count per channel: +1 on an accepted write, −1 on an accepted read, unchanged when both occur on the same channel. Range is 0..2**AWIDTH, so the count is AWIDTH+1 bits wide.
- Flags are decoded combinationally from the registered counts:
  - full = (count == 2**AWIDTH).
  - empty = (count == 0).
  - almost_full = (count ≥ ALMOST_FULL_VALUE).
  - almost_empty = (count < ALMOST_EMPTY_VALUE).
- Writes and reads on different channels are fully independent in the same cycle.
- srst_i has priority over any request in the same cycle.
  - Clears all pointers and counts, rd_valid_o, rd_ch_o and q_o.
  - RAM contents are not cleared.
  - A read accepted in the cycle before srst_i still presents its data; in the srst_i cycle itself nothing is accepted.
- Reset values:
  - q_o = 0, rd_valid_o = 0, rd_ch_o = 0, usedw_o = 0.
  - empty_o = all 1s, full_o = all 0s, almost_full_o = all 0s.
  - almost_empty_o = all 1s if ALMOST_EMPTY_VALUE > 0, else all 0s.

## Timing
- Write accepted at edge k: usedw and flags reflect it after edge k. The word is readable by a request at edge k+1.
- Read accepted at edge k: q_o, rd_ch_o and rd_valid_o = 1 are valid after edge k, for one cycle.
- Latency is 1 cycle and throughput is one read per cycle with no bubbles.
- When no read is accepted, rd_valid_o = 0 and q_o holds its previous value.
- Back-to-back reads of one channel down to empty: the last accepted read returns the final word, and the next request is rejected.

## Configuration
- MC_FIFO_ERR_EN defined adds two ports:
  - ovf_o  out  CHANNELS: sticky per-channel flag. Set when a write to that channel is rejected because it is full.
  - udf_o  out  CHANNELS: sticky per-channel flag. Set when a read of that channel is rejected because it is empty.
  - Both are cleared only by srst_i, with reset value 0.
  - Out-of-range channel requests set no flag.
- MC_FIFO_ERR_EN undefined: ports absent, rejected requests dropped silently, otherwise identical behaviour.

## Test plan
Parameters: CHANNELS=4, DWIDTH=8, AWIDTH=3, ALMOST_FULL_VALUE=6, ALMOST_EMPTY_VALUE=2.
- Isolation and ordering: write 0x10,0x11 to ch1, then 0x20 to ch2, then read ch1, ch2, ch1. Expect q_o = 0x10, 0x20, 0x11 with rd_ch_o = 1, 2, 1; usedw for ch0/ch3 stays 0.
- Thresholds and full: 8 writes to ch0.
  - almost_empty_o[0] falls after write 2; almost_full_o[0] rises after write 6; full_o[0] rises after write 8.
  - A 9th write is dropped; ovf_o[0] = 1 with the macro defined.
- Wrap-around: 20 interleaved write/read pairs on ch3, data = index. Expect reads return 0..19 in order; count stays ≤1; pointers wrap twice.
- Simultaneous events:
  - On ch2 at count 8: write plus read in the same cycle → read returns the oldest word, write dropped, count = 7.
  - On ch2 at count 0: write plus read in the same cycle → read rejected (udf_o[2] = 1), count = 1.
- Reset mid-operation: fill ch0 to 5 and ch1 to 3, read ch0, assert srst_i for 1 cycle together with wrreq_i on ch1.
  - Prior read data appears with rd_valid_o = 1.
  - After reset: all usedw = 0, empty_o = 4'hF, ovf_o/udf_o = 0, and the ch1 write is not stored.

Source files
------------

// File: rtl/mc_fifo.sv
// Multi-channel synchronous FIFO: CHANNELS logical queues share one write and one read port.
// Define MC_FIFO_ERR_EN to add the sticky per-channel overflow/underflow ports ovf_o/udf_o.
module mc_fifo #(
    parameter int CHANNELS           = 4,
    parameter int DWIDTH             = 32,
    parameter int AWIDTH             = 4,
    parameter int ALMOST_FULL_VALUE  = 12,
    parameter int ALMOST_EMPTY_VALUE = 4,
    localparam int CWIDTH            = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                           clk_i,
    input  logic                           srst_i,
    input  logic [DWIDTH-1:0]              data_i,
    input  logic                           wrreq_i,
    input  logic [CWIDTH-1:0]              wrch_i,
    input  logic                           rdreq_i,
    input  logic [CWIDTH-1:0]              rdch_i,
    output logic [DWIDTH-1:0]              q_o,
    output logic                           rd_valid_o,
    output logic [CWIDTH-1:0]              rd_ch_o,
    output logic [CHANNELS*(AWIDTH+1)-1:0] usedw_o,
    output logic [CHANNELS-1:0]            full_o,
    output logic [CHANNELS-1:0]            empty_o,
    output logic [CHANNELS-1:0]            almost_full_o,
    output logic [CHANNELS-1:0]            almost_empty_o
`ifdef MC_FIFO_ERR_EN
    ,
    output logic [CHANNELS-1:0]            ovf_o,
    output logic [CHANNELS-1:0]            udf_o
`endif
);

    localparam int                DEPTH    = 2 ** AWIDTH;
    localparam int                CNTW     = AWIDTH + 1;
    localparam int                MEMW     = CWIDTH + AWIDTH;
    localparam logic [CNTW-1:0]   CNT_FULL = CNTW'(DEPTH);

    logic [DWIDTH-1:0]   r_mem  [CHANNELS*DEPTH];
    logic [AWIDTH-1:0]   r_wptr [CHANNELS];
    logic [AWIDTH-1:0]   r_rptr [CHANNELS];
    logic [CNTW-1:0]     r_cnt  [CHANNELS];

    logic [DWIDTH-1:0]   r_q;
    logic                r_rd_valid;
    logic [CWIDTH-1:0]   r_rd_ch;

    logic [CHANNELS-1:0] w_full;
    logic [CHANNELS-1:0] w_empty;
    logic [CHANNELS-1:0] w_afull;
    logic [CHANNELS-1:0] w_aempty;
    logic [CHANNELS-1:0] w_wr_hit;
    logic [CHANNELS-1:0] w_rd_hit;
    logic [CHANNELS-1:0] w_wr_sel;
    logic [CHANNELS-1:0] w_rd_sel;
    logic                w_wr_any;
    logic                w_rd_any;
    logic [AWIDTH-1:0]   w_wptr_cur;
    logic [AWIDTH-1:0]   w_rptr_cur;
    logic [MEMW-1:0]     w_waddr;
    logic [MEMW-1:0]     w_raddr;

    // Status flags come straight from the registered counts.
    always_comb begin
        w_full   = '0;
        w_empty  = '0;
        w_afull  = '0;
        w_aempty = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_full[c]   = (r_cnt[c] == CNT_FULL);
            w_empty[c]  = (r_cnt[c] == '0);
            w_afull[c]  = (int'(r_cnt[c]) >= ALMOST_FULL_VALUE);
            w_aempty[c] = (int'(r_cnt[c]) < ALMOST_EMPTY_VALUE);
        end
    end

    // Per-channel decode; out-of-range channel selects match no channel and are dropped.
    always_comb begin
        w_wr_hit   = '0;
        w_rd_hit   = '0;
        w_wr_sel   = '0;
        w_rd_sel   = '0;
        w_wptr_cur = '0;
        w_rptr_cur = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_wr_hit[c] = wrreq_i && (wrch_i == CWIDTH'(c));
            w_rd_hit[c] = rdreq_i && (rdch_i == CWIDTH'(c));
            w_wr_sel[c] = w_wr_hit[c] && !w_full[c] && !srst_i;
            w_rd_sel[c] = w_rd_hit[c] && !w_empty[c] && !srst_i;
            if (w_wr_sel[c]) begin
                w_wptr_cur = r_wptr[c];
            end
            if (w_rd_sel[c]) begin
                w_rptr_cur = r_rptr[c];
            end
        end
        w_wr_any = |w_wr_sel;
        w_rd_any = |w_rd_sel;
        w_waddr  = {wrch_i, w_wptr_cur};
        w_raddr  = {rdch_i, w_rptr_cur};
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_wptr[c] <= '0;
                r_rptr[c] <= '0;
                r_cnt[c]  <= '0;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (w_wr_sel[c]) begin
                    r_wptr[c] <= r_wptr[c] + AWIDTH'(1);
                end
                if (w_rd_sel[c]) begin
                    r_rptr[c] <= r_rptr[c] + AWIDTH'(1);
                end
                case ({w_wr_sel[c], w_rd_sel[c]})
                    2'b10:   r_cnt[c] <= r_cnt[c] + CNTW'(1);
                    2'b01:   r_cnt[c] <= r_cnt[c] - CNTW'(1);
                    default: r_cnt[c] <= r_cnt[c];
                endcase
            end
        end
    end

    // Storage is never reset; the pointers alone define what is valid.
    always_ff @(posedge clk_i) begin
        if (w_wr_any) begin
            r_mem[w_waddr] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_q        <= '0;
            r_rd_valid <= 1'b0;
            r_rd_ch    <= '0;
        end else begin
            r_rd_valid <= w_rd_any;
            if (w_rd_any) begin
                r_q     <= r_mem[w_raddr];
                r_rd_ch <= rdch_i;
            end
        end
    end

`ifdef MC_FIFO_ERR_EN
    logic [CHANNELS-1:0] r_ovf;
    logic [CHANNELS-1:0] r_udf;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_ovf <= '0;
            r_udf <= '0;
        end else begin
            r_ovf <= r_ovf | (w_wr_hit & w_full);
            r_udf <= r_udf | (w_rd_hit & w_empty);
        end
    end

    assign ovf_o = r_ovf;
    assign udf_o = r_udf;
`endif

    always_comb begin
        usedw_o = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            usedw_o[c*CNTW +: CNTW] = r_cnt[c];
        end
    end

    assign q_o            = r_q;
    assign rd_valid_o     = r_rd_valid;
    assign rd_ch_o        = r_rd_ch;
    assign full_o         = w_full;
    assign empty_o        = w_empty;
    assign almost_full_o  = w_afull;
    assign almost_empty_o = w_aempty;

endmodule

// File: tb/tb_mc_fifo.sv
// Directed bench for mc_fifo with a 4-channel, 8-deep-per-channel, 8-bit configuration.
module tb_mc_fifo;

    localparam int CH  = 4;
    localparam int DW  = 8;
    localparam int AW  = 3;
    localparam int AFV = 6;
    localparam int AEV = 2;
    localparam int CW  = 2;

    logic            clk = 1'b0;
    logic            srst;
    logic [DW-1:0]   data;
    logic            wrreq;
    logic [CW-1:0]   wrch;
    logic            rdreq;
    logic [CW-1:0]   rdch;
    logic [DW-1:0]   q;
    logic            rd_valid;
    logic [CW-1:0]   rd_ch;
    logic [CH*(AW+1)-1:0] usedw;
    logic [CH-1:0]   full, empty, afull, aempty;
`ifdef MC_FIFO_ERR_EN
    logic [CH-1:0]   ovf, udf;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    mc_fifo #(
        .CHANNELS(CH), .DWIDTH(DW), .AWIDTH(AW),
        .ALMOST_FULL_VALUE(AFV), .ALMOST_EMPTY_VALUE(AEV)
    ) dut (
        .clk_i(clk), .srst_i(srst), .data_i(data),
        .wrreq_i(wrreq), .wrch_i(wrch), .rdreq_i(rdreq), .rdch_i(rdch),
        .q_o(q), .rd_valid_o(rd_valid), .rd_ch_o(rd_ch), .usedw_o(usedw),
        .full_o(full), .empty_o(empty),
        .almost_full_o(afull), .almost_empty_o(aempty)
`ifdef MC_FIFO_ERR_EN
        , .ovf_o(ovf), .udf_o(udf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          srst;
        logic          wr;
        logic [CW-1:0] wch;
        logic [DW-1:0] d;
        logic          rd;
        logic [CW-1:0] rch;
        logic          ev;
        logic [DW-1:0] eq;
        logic [CW-1:0] erc;
        int            cnt [CH];
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic s, input logic w, input int wc, input int d,
                                input logic r, input int rc, input logic ev, input int eq,
                                input int erc, input int c0, input int c1, input int c2,
                                input int c3);
        vec_t v;
        v.srst = s;  v.wr = w;  v.wch = CW'(wc);  v.d = DW'(d);
        v.rd = r;  v.rch = CW'(rc);  v.ev = ev;  v.eq = DW'(eq);  v.erc = CW'(erc);
        v.cnt[0] = c0;  v.cnt[1] = c1;  v.cnt[2] = c2;  v.cnt[3] = c3;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic s, input logic w, input int wc, input int d,
                       input logic r, input int rc);
        srst  = s;
        wrreq = w;
        wrch  = CW'(wc);
        data  = DW'(d);
        rdreq = r;
        rdch  = CW'(rc);
        @(posedge clk);
        #1;
        srst  = 1'b0;
        wrreq = 1'b0;
        rdreq = 1'b0;
    endtask

    function automatic logic [3:0] uw(input int c);
        return usedw[c*(AW+1) +: AW+1];
    endfunction

    // Expected flags decoded from the expected counts.
    task automatic chk_counts(input string tag, input int cnt [CH]);
        logic [CH-1:0] ef, ee, eaf, eae;
        logic [CH*(AW+1)-1:0] eu;
        for (int c = 0; c < CH; c++) begin
            eu[c*(AW+1) +: AW+1] = 4'(cnt[c]);
            ef[c]  = (cnt[c] == 8);
            ee[c]  = (cnt[c] == 0);
            eaf[c] = (cnt[c] >= AFV);
            eae[c] = (cnt[c] < AEV);
        end
        chk({tag, " usedw"}, 32'(usedw), 32'(eu));
        chk({tag, " full"}, 32'(full), 32'(ef));
        chk({tag, " empty"}, 32'(empty), 32'(ee));
        chk({tag, " almost_full"}, 32'(afull), 32'(eaf));
        chk({tag, " almost_empty"}, 32'(aempty), 32'(eae));
    endtask

    initial begin
        int zc [CH];
        for (int c = 0; c < CH; c++) zc[c] = 0;

        srst = 1'b1; wrreq = 1'b0; rdreq = 1'b0; wrch = '0; rdch = '0; data = '0;
        @(posedge clk);
        #1;
        cyc(1'b1, 0, 0, 0, 0, 0);
        chk("reset rd_valid", 32'(rd_valid), 32'd0);
        chk("reset q", 32'(q), 32'd0);
        chk("reset rd_ch", 32'(rd_ch), 32'd0);
        chk_counts("reset", zc);
`ifdef MC_FIFO_ERR_EN
        chk("reset ovf", 32'(ovf), 32'd0);
        chk("reset udf", 32'(udf), 32'd0);
`endif

        // Isolation and ordering across ch1/ch2, then fill ch0 to full.
        tbl.push_back(mk(0, 1, 1, 'h10, 0, 0, 0, 'h00, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 'h11, 0, 0, 0, 'h00, 0, 0, 2, 0, 0));
        tbl.push_back(mk(0, 1, 2, 'h20, 0, 0, 0, 'h00, 0, 0, 2, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 'h10, 1, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 2, 1, 'h20, 2, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 'h11, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 'h11, 0, 0, 0, 0, 0));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(0, 1, 0, 'hA0 + i, 0, 0, 0, 'h11, 0, i + 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 'hA8, 0, 0, 0, 'h11, 0, 8, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 'h30, 1, 0, 1, 'hA0, 0, 7, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 'h30, 1, 7, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 'hA1, 0, 6, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            cyc(tbl[i].srst, tbl[i].wr, int'(tbl[i].wch), int'(tbl[i].d),
                tbl[i].rd, int'(tbl[i].rch));
            chk({tag, " rd_valid"}, 32'(rd_valid), 32'(tbl[i].ev));
            chk({tag, " q"}, 32'(q), 32'(tbl[i].eq));
            if (tbl[i].ev) chk({tag, " rd_ch"}, 32'(rd_ch), 32'(tbl[i].erc));
            chk_counts(tag, tbl[i].cnt);
        end
`ifdef MC_FIFO_ERR_EN
        chk("ovf after 9th write", 32'(ovf), 32'h1);
        chk("udf after empty read", 32'(udf), 32'h2);
`endif

        cyc(1'b1, 0, 0, 0, 0, 0);
        chk_counts("reset2", zc);
`ifdef MC_FIFO_ERR_EN
        chk("reset2 ovf", 32'(ovf), 32'd0);
        chk("reset2 udf", 32'(udf), 32'd0);
`endif

        // Wrap-around on ch3.
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 1, 3, i, 0, 0);
            chk($sformatf("wrap%0d usedw3 after write", i), 32'(uw(3)), 32'd1);
            cyc(1'b0, 0, 0, 0, 1, 3);
            chk($sformatf("wrap%0d rd_valid", i), 32'(rd_valid), 32'd1);
            chk($sformatf("wrap%0d q", i), 32'(q), 32'(i));
            chk($sformatf("wrap%0d usedw3 after read", i), 32'(uw(3)), 32'd0);
        end

        // ch2 full: simultaneous write+read keeps oldest data, drops the write.
        for (int i = 0; i < 8; i++) cyc(1'b0, 1, 2, 'h50 + i, 0, 0);
        chk("ch2 full", 32'(full[2]), 32'd1);
        cyc(1'b0, 1, 2, 'h99, 1, 2);
        chk("ch2 full wr+rd valid", 32'(rd_valid), 32'd1);
        chk("ch2 full wr+rd q", 32'(q), 32'h50);
        chk("ch2 full wr+rd usedw", 32'(uw(2)), 32'd7);
        chk("ch2 full wr+rd full", 32'(full[2]), 32'd0);
        for (int i = 1; i < 8; i++) begin
            cyc(1'b0, 0, 0, 0, 1, 2);
            chk($sformatf("ch2 drain%0d q", i), 32'(q), 32'('h50 + i));
        end
        chk("ch2 drained empty", 32'(empty[2]), 32'd1);
        cyc(1'b0, 1, 2, 'h77, 1, 2);
        chk("ch2 empty wr+rd valid", 32'(rd_valid), 32'd0);
        chk("ch2 empty wr+rd usedw", 32'(uw(2)), 32'd1);
`ifdef MC_FIFO_ERR_EN
        chk("ch2 ovf", 32'(ovf), 32'h4);
        chk("ch2 udf", 32'(udf), 32'h4);
`endif
        cyc(1'b0, 0, 0, 0, 1, 2);
        chk("ch2 late read valid", 32'(rd_valid), 32'd1);
        chk("ch2 late read q", 32'(q), 32'h77);

        // Reset mid-operation with a pending read and a concurrent write.
        cyc(1'b1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1, 0, 'hC0 + i, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1, 1, 'hD0 + i, 0, 0);
        cyc(1'b0, 0, 0, 0, 1, 0);
        chk("pre-reset read valid", 32'(rd_valid), 32'd1);
        chk("pre-reset read q", 32'(q), 32'hC0);
        chk("pre-reset read rd_ch", 32'(rd_ch), 32'd0);
        chk("pre-reset usedw0", 32'(uw(0)), 32'd4);
        chk("pre-reset usedw1", 32'(uw(1)), 32'd3);
        cyc(1'b1, 1, 1, 'hEE, 0, 0);
        chk("mid reset rd_valid", 32'(rd_valid), 32'd0);
        chk("mid reset q", 32'(q), 32'd0);
        chk_counts("mid reset", zc);
`ifdef MC_FIFO_ERR_EN
        chk("mid reset ovf", 32'(ovf), 32'd0);
        chk("mid reset udf", 32'(udf), 32'd0);
`endif
        cyc(1'b0, 0, 0, 0, 1, 1);
        chk("post reset ch1 read rejected", 32'(rd_valid), 32'd0);
        cyc(1'b0, 1, 1, 'hF1, 0, 0);
        chk("post reset ch1 usedw", 32'(uw(1)), 32'd1);
        cyc(1'b0, 0, 0, 0, 1, 1);
        chk("post reset ch1 valid", 32'(rd_valid), 32'd1);
        chk("post reset ch1 q", 32'(q), 32'hF1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
